// File: rtl/mem_responder.sv
// Word-addressed memory responder with req/ready handshake and wait states.
// Optional access counters (rd_cnt/wr_cnt) enabled by `define MEM_ACCESS_CNT_EN.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              req,
    input  logic              we,
    input  logic              oe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              ready,
    output logic              err
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt
`endif
);

    localparam int WS = (WAIT_STATES < 0 || WAIT_STATES > 15)
                      ? 15 : WAIT_STATES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_q, oe_q;
    logic              accept, enter_resp;

    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_we, e_oe;
    logic              in_range, is_wr, is_rd, bad;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs && req) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WS);
                    state_d = (WS == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP);

    // With zero wait states the commit edge is also the capture edge,
    // so the live request fields are used while still in IDLE.
    always_comb begin
        e_addr = addr_q;
        e_data = data_q;
        e_we   = we_q;
        e_oe   = oe_q;
        if (state_q == IDLE) begin
            e_addr = addr;
            e_data = dataIn;
            e_we   = we;
            e_oe   = oe;
        end
    end

    assign in_range = {1'b0, e_addr} < (ADDR_W+1)'(DEPTH);
    assign is_wr    = e_we;
    assign is_rd    = !e_we && e_oe;
    assign bad      = !in_range || (!e_we && !e_oe);
    assign idx      = e_addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready   <= 1'b0;
            err     <= 1'b0;
            dataOut <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready   <= enter_resp;
            err     <= enter_resp && bad;
            if (enter_resp && is_rd)
                dataOut <= in_range ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= addr;
            data_q <= dataIn;
            we_q   <= we;
            oe_q   <= oe;
        end
    end

    // Storage survives reset; only the commit is gated by it.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && is_wr && in_range)
            mem[idx] <= e_data;
    end

`ifdef MEM_ACCESS_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else if (enter_resp && !bad) begin
            if (is_wr)
                wr_cnt <= wr_cnt + 16'd1;
            else if (is_rd)
                rd_cnt <= rd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed-vector bench for mem_responder (wait-state and zero-wait instances).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_a, req_a, we_a, oe_a;
    logic [31:0] addr_a, din_a, dout_a;
    logic        rdy_a, err_a;
    logic        cs_b, req_b, we_b, oe_b;
    logic [31:0] addr_b, din_b, dout_b;
    logic        rdy_b, err_b;
`ifdef MEM_ACCESS_CNT_EN
    logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(2)) u_a (
        .clk(clk), .reset(reset), .cs(cs_a), .req(req_a),
        .we(we_a), .oe(oe_a), .addr(addr_a), .dataIn(din_a),
        .dataOut(dout_a), .ready(rdy_a), .err(err_a)
`ifdef MEM_ACCESS_CNT_EN
        , .rd_cnt(rdc_a), .wr_cnt(wrc_a)
`endif
    );

    mem_responder #(.WAIT_STATES(0)) u_b (
        .clk(clk), .reset(reset), .cs(cs_b), .req(req_b),
        .we(we_b), .oe(oe_b), .addr(addr_b), .dataIn(din_b),
        .dataOut(dout_b), .ready(rdy_b), .err(err_b)
`ifdef MEM_ACCESS_CNT_EN
        , .rd_cnt(rdc_b), .wr_cnt(wrc_b)
`endif
    );

    typedef struct {
        logic        w;
        logic        o;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] q;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic acc_a(input logic w, input logic o,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic e, output logic [31:0] q,
                         output int lat);
        @(negedge clk);
        cs_a = 1'b1; req_a = 1'b1;
        we_a = w; oe_a = o; addr_a = a; din_a = d;
        @(posedge clk); #1;
        req_a = 1'b0; cs_a = 1'b0;
        we_a = ~w; oe_a = ~o; addr_a = ~a; din_a = ~d;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (rdy_a) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        e = err_a;
        q = dout_a;
    endtask

    initial begin
        logic        e;
        logic [31:0] q;
        int          lat;
        int          seen;
        int          wr_exp;
        int          rd_exp;
        logic [31:0] bexp [4];

        vt[0]  = '{1'b1, 1'b0, 32'd5,        32'hDEADBEEF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 1'b1, 32'd5,        32'h0,        1'b0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 1'b1, 32'd3,        32'h00000033, 1'b0, 32'hDEADBEEF};
        vt[3]  = '{1'b0, 1'b1, 32'd3,        32'h0,        1'b0, 32'h00000033};
        vt[4]  = '{1'b0, 1'b1, 32'd1024,     32'h0,        1'b1, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 32'd976,      32'h00000976, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 32'd2000,     32'h0BAD0BAD, 1'b1, 32'h0};
        vt[7]  = '{1'b0, 1'b1, 32'd976,      32'h0,        1'b0, 32'h00000976};
        vt[8]  = '{1'b0, 1'b0, 32'd5,        32'h0,        1'b1, 32'h00000976};
        vt[9]  = '{1'b0, 1'b1, 32'h80000005, 32'h0,        1'b1, 32'h0};
        vt[10] = '{1'b1, 1'b0, 32'd1023,     32'hCAFEF00D, 1'b0, 32'h0};
        vt[11] = '{1'b0, 1'b1, 32'd1023,     32'h0,        1'b0, 32'hCAFEF00D};

        reset = 1'b0;
        cs_a = 0; req_a = 0; we_a = 0; oe_a = 0; addr_a = 0; din_a = 0;
        cs_b = 0; req_b = 0; we_b = 0; oe_b = 0; addr_b = 0; din_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, rdy_a}, 32'h0);
        chk("rst_err",   {31'b0, err_a}, 32'h0);
        chk("rst_dout",  dout_a, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // cs low: request must be ignored
        @(negedge clk);
        req_a = 1'b1; oe_a = 1'b1; cs_a = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rdy_a) seen++;
        end
        req_a = 1'b0; oe_a = 1'b0;
        chk("cs_low_ignored", 32'(seen), 32'd0);

        wr_exp = 0;
        rd_exp = 0;
        for (int i = 0; i < 12; i++) begin
            acc_a(vt[i].w, vt[i].o, vt[i].a, vt[i].d, e, q, lat);
            chk($sformatf("v%0d_lat", i),  32'(lat), 32'd2);
            chk($sformatf("v%0d_err", i),  {31'b0, e}, {31'b0, vt[i].e});
            chk($sformatf("v%0d_dout", i), q, vt[i].q);
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse", i), {30'b0, rdy_a, err_a}, 32'h0);
            if (!vt[i].e && vt[i].w) wr_exp++;
            else if (!vt[i].e && vt[i].o) rd_exp++;
        end
`ifdef MEM_ACCESS_CNT_EN
        chk("wr_cnt", {16'b0, wrc_a}, 32'(wr_exp));
        chk("rd_cnt", {16'b0, rdc_a}, 32'(rd_exp));
`endif

        // zero wait states, req held high across back-to-back accesses
        bexp[0] = 32'h0;
        bexp[1] = 32'h0;
        bexp[2] = 32'h11;
        bexp[3] = 32'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cs_b = 1'b1; req_b = 1'b1;
            we_b = (i < 2); oe_b = (i >= 2);
            addr_b = 32'(i % 2);
            din_b = (i % 2 == 0) ? 32'h11 : 32'h22;
            @(posedge clk); #1;
            chk($sformatf("b%0d_ready", i), {31'b0, rdy_b}, 32'h1);
            chk($sformatf("b%0d_err", i),   {31'b0, err_b}, 32'h0);
            chk($sformatf("b%0d_dout", i),  dout_b, bexp[i]);
            @(posedge clk); #1;
            chk($sformatf("b%0d_gap", i),   {31'b0, rdy_b}, 32'h0);
        end
        @(negedge clk);
        cs_b = 1'b0; req_b = 1'b0;
`ifdef MEM_ACCESS_CNT_EN
        chk("b_wr_cnt", {16'b0, wrc_b}, 32'd2);
        chk("b_rd_cnt", {16'b0, rdc_b}, 32'd2);
`endif

        // reset during WAIT aborts the pending write
        acc_a(1'b1, 1'b0, 32'd7, 32'h11110007, e, q, lat);
        chk("w7_err", {31'b0, e}, 32'h0);
        chk("w7_dout", q, 32'hCAFEF00D);
        @(negedge clk);
        cs_a = 1'b1; req_a = 1'b1; we_a = 1'b1; oe_a = 1'b0;
        addr_a = 32'd7; din_a = 32'hA5A5A5A5;
        @(posedge clk); #1;
        req_a = 1'b0; cs_a = 1'b0;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("mid_rst_ready", {31'b0, rdy_a}, 32'h0);
            chk("mid_rst_err",   {31'b0, err_a}, 32'h0);
            chk("mid_rst_dout",  dout_a, 32'h0);
        end
`ifdef MEM_ACCESS_CNT_EN
        chk("rst_wr_cnt", {16'b0, wrc_a}, 32'd0);
        chk("rst_rd_cnt", {16'b0, rdc_a}, 32'd0);
`endif
        reset = 1'b1;
        acc_a(1'b0, 1'b1, 32'd7, 32'h0, e, q, lat);
        chk("r7_lat",  32'(lat), 32'd2);
        chk("r7_err",  {31'b0, e}, 32'h0);
        chk("r7_dout", q, 32'h11110007);
`ifdef MEM_ACCESS_CNT_EN
        chk("r7_rd_cnt", {16'b0, rdc_a}, 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
